axi_io_pmp_rd_ctrl: RTL and testbench

Read-channel sequencer for the AXI IO-PMP. It sits between the slave-side AR/R channels and the downstream master port. It holds each incoming read request, presents its address to a PMP checker, and then takes one of two actions. An allowed request is forwarded downstream. A denied request is never issued; the block completes it locally with SLVERR beats, preserving AXI response ordering. It also keeps a sticky first-fault record and a fault counter for the configuration software.

---
 rtl/axi_io_pmp_rd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_io_pmp_rd_ctrl.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_io_pmp_rd_ctrl.sv
// ---------------------------------------------------------------------------
// axi_io_pmp_rd_ctrl
//
// Read-channel sequencer for the AXI IO-PMP. Holds one slave-side AR request
// at a time, presents its address to an external combinational PMP checker,
// then either forwards the request to the master port or, if the access is
// denied, completes it locally with SLVERR beats. Also records the first
// denied read and a saturating count of denials.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   s_ar_*                  slave AR channel (request in)
//   m_ar_*                  master AR channel (registered request out)
//   m_r_*                   master R channel (downstream data in)
//   s_r_*                   slave R channel (data / SLVERR beats out)
//   pmp_addr_o              address under check (latched AR address, PLEN bits)
//   pmp_allow_i             combinational PMP read verdict for pmp_addr_o
//   fault_valid_o           sticky: a denied read has been recorded
//   fault_addr_o/fault_id_o address/id of the first denied read since clear
//   fault_cnt_o             number of denied reads, saturating at 16'hFFFF
//   fault_clear_i           one-cycle pulse clearing fault_valid_o/fault_cnt_o
// ---------------------------------------------------------------------------
module axi_io_pmp_rd_ctrl #(
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 8,
  parameter int DATA_WIDTH      = 64,
  parameter int PLEN            = 56,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // slave AR
  input  logic                  s_ar_valid_i,
  output logic                  s_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr_i,
  input  logic [ID_WIDTH-1:0]   s_ar_id_i,
  input  logic [7:0]            s_ar_len_i,
  input  logic [2:0]            s_ar_size_i,
  input  logic [1:0]            s_ar_burst_i,
  // master AR
  output logic                  m_ar_valid_o,
  input  logic                  m_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic [ID_WIDTH-1:0]   m_ar_id_o,
  output logic [7:0]            m_ar_len_o,
  output logic [2:0]            m_ar_size_o,
  output logic [1:0]            m_ar_burst_o,
  // master R
  input  logic                  m_r_valid_i,
  output logic                  m_r_ready_o,
  input  logic [DATA_WIDTH-1:0] m_r_data_i,
  input  logic [ID_WIDTH-1:0]   m_r_id_i,
  input  logic [1:0]            m_r_resp_i,
  input  logic                  m_r_last_i,
  // slave R
  output logic                  s_r_valid_o,
  input  logic                  s_r_ready_i,
  output logic [DATA_WIDTH-1:0] s_r_data_o,
  output logic [ID_WIDTH-1:0]   s_r_id_o,
  output logic [1:0]            s_r_resp_o,
  output logic                  s_r_last_o,
  // PMP checker
  output logic [PLEN-1:0]       pmp_addr_o,
  input  logic                  pmp_allow_i,
  // fault log
  output logic                  fault_valid_o,
  output logic [ADDR_WIDTH-1:0] fault_addr_o,
  output logic [ID_WIDTH-1:0]   fault_id_o,
  output logic [15:0]           fault_cnt_o,
  input  logic                  fault_clear_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] FWD   = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]            state;
  logic [1:0]            state_nxt;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [ID_WIDTH-1:0]   lat_id;
  logic [7:0]            lat_len;
  logic [2:0]            lat_size;
  logic [1:0]            lat_burst;

  logic [7:0]            beat_cnt;
  logic [CNT_W-1:0]      out_cnt;

  logic                  ar_hs;
  logic                  m_ar_hs;
  logic                  m_r_last_hs;
  logic                  err_beat_hs;
  logic                  fwd_ok;
  logic                  deny_rec;
  logic                  in_err;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_err      = (state == ERR);
  assign ar_hs       = s_ar_valid_i && s_ar_ready_o;
  assign m_ar_hs     = m_ar_valid_o && m_ar_ready_i;
  assign m_r_last_hs = m_r_valid_i && m_r_ready_o && m_r_last_i;
  assign err_beat_hs = in_err && s_r_ready_i;

  // A denied request is only completed locally once nothing forwarded is
  // still in flight, so its SLVERR beats cannot overtake earlier responses.
  assign fwd_ok   = (state == CHECK) && pmp_allow_i && (out_cnt < MAX_CNT);
  assign deny_rec = (state == CHECK) && !pmp_allow_i && (out_cnt == '0);

  // AR side
  assign s_ar_ready_o = (state == IDLE);
  assign m_ar_valid_o = (state == FWD);
  assign m_ar_addr_o  = lat_addr;
  assign m_ar_id_o    = lat_id;
  assign m_ar_len_o   = lat_len;
  assign m_ar_size_o  = lat_size;
  assign m_ar_burst_o = lat_burst;
  assign pmp_addr_o   = lat_addr[PLEN-1:0];

  // R side: local SLVERR beats while in ERR, transparent passthrough otherwise
  assign s_r_valid_o = in_err ? 1'b1 : m_r_valid_i;
  assign s_r_data_o  = in_err ? {DATA_WIDTH{1'b1}} : m_r_data_i;
  assign s_r_id_o    = in_err ? lat_id : m_r_id_i;
  assign s_r_resp_o  = in_err ? RESP_SLVERR : m_r_resp_i;
  assign s_r_last_o  = in_err ? (beat_cnt == 8'd0) : m_r_last_i;
  assign m_r_ready_o = in_err ? 1'b0 : s_r_ready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_hs) state_nxt = CHECK;
      CHECK: begin
        if (fwd_ok)        state_nxt = FWD;
        else if (deny_rec) state_nxt = ERR;
      end
      FWD:     if (m_ar_hs) state_nxt = IDLE;
      ERR:     if (err_beat_hs && s_r_last_o) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Request payload is captured once on acceptance and held for the whole
  // CHECK/FWD/ERR lifetime, which keeps m_ar_* stable while m_ar_valid_o waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_addr  <= '0;
      lat_id    <= '0;
      lat_len   <= '0;
      lat_size  <= '0;
      lat_burst <= '0;
    end else if (ar_hs) begin
      lat_addr  <= s_ar_addr_i;
      lat_id    <= s_ar_id_i;
      lat_len   <= s_ar_len_i;
      lat_size  <= s_ar_size_i;
      lat_burst <= s_ar_burst_i;
    end
  end

  // Remaining SLVERR beats after the current one; the final beat leaves it at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt <= 8'd0;
    end else if (deny_rec) begin
      beat_cnt <= lat_len;
    end else if (err_beat_hs && (beat_cnt != 8'd0)) begin
      beat_cnt <= beat_cnt - 8'd1;
    end
  end

  // Forwarded reads still awaiting their last R beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt <= '0;
    end else begin
      case ({m_ar_hs, m_r_last_hs})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Fault log. A clear coinciding with a new denial wipes the old record
  // first, so the new denial becomes the first fault with a count of one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_valid_o <= 1'b0;
      fault_addr_o  <= '0;
      fault_id_o    <= '0;
      fault_cnt_o   <= 16'd0;
    end else if (fault_clear_i) begin
      fault_valid_o <= deny_rec;
      fault_cnt_o   <= deny_rec ? 16'd1 : 16'd0;
      if (deny_rec) begin
        fault_addr_o <= lat_addr;
        fault_id_o   <= lat_id;
      end
    end else if (deny_rec) begin
      fault_cnt_o <= sat_inc16(fault_cnt_o);
      if (!fault_valid_o) begin
        fault_valid_o <= 1'b1;
        fault_addr_o  <= lat_addr;
        fault_id_o    <= lat_id;
      end
    end
  end

endmodule

// File: tb/tb_axi_io_pmp_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_io_pmp_rd_ctrl
//
// Bench for axi_io_pmp_rd_ctrl with MAX_OUTSTANDING = 2. A transaction-level
// model of the request lifecycle predicts every output each cycle; directed
// scenarios add literal expectations, followed by a randomized phase.
// PMP policy (pmp_mode): 0 = allow iff address bit 12 clear, 1 = allow all,
// 2 = deny all.
// ---------------------------------------------------------------------------
module tb_axi_io_pmp_rd_ctrl;

  localparam int AW   = 64;
  localparam int IW   = 8;
  localparam int DW   = 64;
  localparam int PL   = 56;
  localparam int MAXO = 2;

  logic          clk;
  logic          rst_n;
  logic          s_ar_valid_i;
  logic          s_ar_ready_o;
  logic [AW-1:0] s_ar_addr_i;
  logic [IW-1:0] s_ar_id_i;
  logic [7:0]    s_ar_len_i;
  logic [2:0]    s_ar_size_i;
  logic [1:0]    s_ar_burst_i;
  logic          m_ar_valid_o;
  logic          m_ar_ready_i;
  logic [AW-1:0] m_ar_addr_o;
  logic [IW-1:0] m_ar_id_o;
  logic [7:0]    m_ar_len_o;
  logic [2:0]    m_ar_size_o;
  logic [1:0]    m_ar_burst_o;
  logic          m_r_valid_i;
  logic          m_r_ready_o;
  logic [DW-1:0] m_r_data_i;
  logic [IW-1:0] m_r_id_i;
  logic [1:0]    m_r_resp_i;
  logic          m_r_last_i;
  logic          s_r_valid_o;
  logic          s_r_ready_i;
  logic [DW-1:0] s_r_data_o;
  logic [IW-1:0] s_r_id_o;
  logic [1:0]    s_r_resp_o;
  logic          s_r_last_o;
  logic [PL-1:0] pmp_addr_o;
  logic          pmp_allow_i;
  logic          fault_valid_o;
  logic [AW-1:0] fault_addr_o;
  logic [IW-1:0] fault_id_o;
  logic [15:0]   fault_cnt_o;
  logic          fault_clear_i;

  logic [1:0]    pmp_mode;
  bit            rnd;
  bit            r_hold;
  bit            chk_en;
  int            vectors;
  int            miscompares;

  axi_io_pmp_rd_ctrl #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW), .PLEN(PL), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o), .s_ar_addr_i(s_ar_addr_i),
    .s_ar_id_i(s_ar_id_i), .s_ar_len_i(s_ar_len_i), .s_ar_size_i(s_ar_size_i),
    .s_ar_burst_i(s_ar_burst_i),
    .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i), .m_ar_addr_o(m_ar_addr_o),
    .m_ar_id_o(m_ar_id_o), .m_ar_len_o(m_ar_len_o), .m_ar_size_o(m_ar_size_o),
    .m_ar_burst_o(m_ar_burst_o),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_data_i(m_r_data_i),
    .m_r_id_i(m_r_id_i), .m_r_resp_i(m_r_resp_i), .m_r_last_i(m_r_last_i),
    .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i), .s_r_data_o(s_r_data_o),
    .s_r_id_o(s_r_id_o), .s_r_resp_o(s_r_resp_o), .s_r_last_o(s_r_last_o),
    .pmp_addr_o(pmp_addr_o), .pmp_allow_i(pmp_allow_i),
    .fault_valid_o(fault_valid_o), .fault_addr_o(fault_addr_o), .fault_id_o(fault_id_o),
    .fault_cnt_o(fault_cnt_o), .fault_clear_i(fault_clear_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in PMP checker
  always_comb pmp_allow_i = (pmp_mode == 2'd1) || ((pmp_mode == 2'd0) && !pmp_addr_o[12]);

  function automatic bit allow_rule(input logic [PL-1:0] a);
    return (pmp_mode == 2'd1) || ((pmp_mode == 2'd0) && !a[12]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The held request (if any) goes through: waiting for a verdict, presented
  // downstream, or being answered locally with m_left more error beats.
  bit            m_busy, m_check, m_fwd, m_err;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_id;
  logic [7:0]    m_len;
  logic [2:0]    m_size;
  logic [1:0]    m_burst;
  int            m_left, m_out;
  bit            m_fv;
  int            m_fcnt;
  logic [AW-1:0] m_faddr;
  logic [IW-1:0] m_fid;

  task automatic model_reset();
    m_busy = 0; m_check = 0; m_fwd = 0; m_err = 0;
    m_addr = '0; m_id = '0; m_len = '0; m_size = '0; m_burst = '0;
    m_left = 0; m_out = 0;
    m_fv = 0; m_fcnt = 0; m_faddr = '0; m_fid = '0;
  endtask

  task automatic model_step();
    bit err_now, mr_ready, rlast, mar, rec;
    int nout;
    err_now  = m_busy && m_err;
    mr_ready = !err_now && s_r_ready_i;
    rlast    = m_r_valid_i && mr_ready && m_r_last_i;
    mar      = m_busy && m_fwd && m_ar_ready_i;
    nout     = m_out + int'(mar) - int'(rlast);
    rec      = 0;
    if (!m_busy) begin
      if (s_ar_valid_i) begin
        m_busy = 1; m_check = 1; m_fwd = 0; m_err = 0;
        m_addr = s_ar_addr_i; m_id = s_ar_id_i; m_len = s_ar_len_i;
        m_size = s_ar_size_i; m_burst = s_ar_burst_i;
      end
    end else if (m_check) begin
      if (allow_rule(m_addr[PL-1:0])) begin
        if (m_out < MAXO) begin m_check = 0; m_fwd = 1; end
      end else if (m_out == 0) begin
        m_check = 0; m_err = 1; m_left = int'(m_len); rec = 1;
      end
    end else if (mar) begin
      m_busy = 0; m_fwd = 0;
    end else if (m_err && s_r_ready_i) begin
      if (m_left == 0) begin m_busy = 0; m_err = 0; end
      else m_left--;
    end
    m_out = nout;
    if (fault_clear_i) begin
      m_fcnt = rec ? 1 : 0;
      m_fv   = rec;
      if (rec) begin m_faddr = m_addr; m_fid = m_id; end
    end else if (rec) begin
      if (m_fcnt < 65535) m_fcnt++;
      if (!m_fv) begin m_fv = 1; m_faddr = m_addr; m_fid = m_id; end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("s_ar_ready", 64'(s_ar_ready_o), 64'(!m_busy));
        chk("m_ar_valid", 64'(m_ar_valid_o), 64'(m_busy && m_fwd));
        if (m_busy && m_fwd) begin
          chk("m_ar_addr", m_ar_addr_o, m_addr);
          chk("m_ar_id", 64'(m_ar_id_o), 64'(m_id));
          chk("m_ar_len", 64'(m_ar_len_o), 64'(m_len));
          chk("m_ar_size", 64'(m_ar_size_o), 64'(m_size));
          chk("m_ar_burst", 64'(m_ar_burst_o), 64'(m_burst));
        end
        chk("pmp_addr", 64'(pmp_addr_o), 64'(m_addr[PL-1:0]));
        if (m_busy && m_err) begin
          chk("err s_r_valid", 64'(s_r_valid_o), 64'd1);
          chk("err s_r_id", 64'(s_r_id_o), 64'(m_id));
          chk("err s_r_data", s_r_data_o, {64{1'b1}});
          chk("err s_r_resp", 64'(s_r_resp_o), 64'd2);
          chk("err s_r_last", 64'(s_r_last_o), 64'(m_left == 0));
          chk("err m_r_ready", 64'(m_r_ready_o), 64'd0);
        end else begin
          chk("pass s_r_valid", 64'(s_r_valid_o), 64'(m_r_valid_i));
          if (m_r_valid_i) begin
            chk("pass s_r_data", s_r_data_o, m_r_data_i);
            chk("pass s_r_id", 64'(s_r_id_o), 64'(m_r_id_i));
            chk("pass s_r_resp", 64'(s_r_resp_o), 64'(m_r_resp_i));
            chk("pass s_r_last", 64'(s_r_last_o), 64'(m_r_last_i));
          end
          chk("pass m_r_ready", 64'(m_r_ready_o), 64'(s_r_ready_i));
        end
        chk("fault_valid", 64'(fault_valid_o), 64'(m_fv));
        chk("fault_cnt", 64'(fault_cnt_o), 64'(m_fcnt));
        if (m_fv) begin
          chk("fault_addr", fault_addr_o, m_faddr);
          chk("fault_id", 64'(fault_id_o), 64'(m_fid));
        end
      end
    end
  end

  // ---------------- downstream slave ----------------
  logic [IW-1:0] q_id[$];
  logic [7:0]    q_len[$];

  initial begin
    bit            arf, rf;
    logic [IW-1:0] a_id;
    logic [7:0]    a_len;
    int            beat;
    beat = 0;
    m_ar_ready_i = 1'b1; m_r_valid_i = 1'b0; m_r_data_i = '0;
    m_r_id_i = '0; m_r_resp_i = 2'b00; m_r_last_i = 1'b0;
    forever begin
      @(negedge clk);
      arf = m_ar_valid_o && m_ar_ready_i;
      a_id = m_ar_id_o; a_len = m_ar_len_o;
      rf = m_r_valid_i && m_r_ready_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        q_id.delete(); q_len.delete(); m_r_valid_i = 1'b0; beat = 0;
      end else begin
        if (arf) begin q_id.push_back(a_id); q_len.push_back(a_len); end
        if (rf) begin
          if (m_r_last_i) begin void'(q_id.pop_front()); void'(q_len.pop_front()); beat = 0; end
          else beat++;
          m_r_valid_i = 1'b0;
        end
        m_ar_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!m_r_valid_i && (q_id.size() > 0) && !r_hold && (!rnd || ($urandom_range(0, 2) != 0))) begin
          m_r_valid_i = 1'b1;
          m_r_id_i    = q_id[0];
          m_r_data_i  = {$urandom, $urandom};
          m_r_resp_i  = 2'b00;
          m_r_last_i  = (beat == int'(q_len[0]));
        end
      end
    end
  end

  // Requester R ready
  initial begin
    s_r_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_r_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    int n;
    n = 0;
    s_ar_addr_i = a; s_ar_id_i = id; s_ar_len_i = len;
    s_ar_size_i = 3'($urandom_range(0, 3)); s_ar_burst_i = 2'($urandom_range(0, 2));
    s_ar_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ar_ready_o) break;
      n++;
      if (n > 1000) begin
        vectors++; miscompares++;
        $display("FAIL issue_timeout: s_ar_ready stayed %0d, required 1", s_ar_ready_o);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_ar_valid_i = 1'b0;
  endtask

  task automatic wait_state(input int tgt);
    int n;
    n = 0;
    while (m_busy || (m_out != tgt)) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        vectors++; miscompares++;
        $display("FAIL wait_state: out=%0d busy=%0d, required out=%0d idle", m_out, m_busy, tgt);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beat(output logic [1:0] resp, output logic [IW-1:0] id);
    int n;
    n = 0;
    resp = 2'b11; id = '0;
    forever begin
      @(negedge clk);
      if (s_r_valid_o && s_r_ready_i) begin resp = s_r_resp_o; id = s_r_id_o; break; end
      n++;
      if (n > 500) begin
        vectors++; miscompares++;
        $display("FAIL wait_beat: no R beat, required one");
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    fault_clear_i = 1'b1;
    @(posedge clk);
    #1;
    fault_clear_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]    resp;
    logic [IW-1:0] rid;
    int            beats, last_at, mar_seen, gap;
    logic [AW-1:0] ra;
    vectors = 0; miscompares = 0;
    chk_en = 0; rnd = 0; r_hold = 0; pmp_mode = 2'd0;
    rst_n = 1'b0; fault_clear_i = 1'b0;
    s_ar_valid_i = 1'b0; s_ar_addr_i = '0; s_ar_id_i = '0; s_ar_len_i = '0;
    s_ar_size_i = '0; s_ar_burst_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;

    // reset state
    @(negedge clk);
    chk("rst s_ar_ready", 64'(s_ar_ready_o), 64'd1);
    chk("rst m_ar_valid", 64'(m_ar_valid_o), 64'd0);
    chk("rst fault_cnt", 64'(fault_cnt_o), 64'd0);
    chk("rst pmp_addr", 64'(pmp_addr_o), 64'd0);
    @(posedge clk); #1;

    // allowed single read: m_ar_valid two cycles after the AR handshake
    issue(64'h8000_0000, 8'h21, 8'd0);
    @(negedge clk);
    chk("allow check-cycle m_ar_valid", 64'(m_ar_valid_o), 64'd0);
    @(negedge clk);
    chk("allow m_ar_valid", 64'(m_ar_valid_o), 64'd1);
    chk("allow m_ar_addr", m_ar_addr_o, 64'h8000_0000);
    wait_beat(resp, rid);
    chk("allow r resp", 64'(resp), 64'd0);
    chk("allow r id", 64'(rid), 64'h21);
    wait_state(0);

    // denied burst
    issue(64'h1000, 8'h05, 8'd3);
    beats = 0; last_at = 0; mar_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_ar_valid_o) mar_seen = 1;
      if (s_r_valid_o && s_r_ready_i && (s_r_resp_o == 2'b10)) begin
        beats++;
        if (s_r_last_o) last_at = beats;
      end
    end
    chk("deny beats", 64'(beats), 64'd4);
    chk("deny last beat index", 64'(last_at), 64'd4);
    chk("deny m_ar never", 64'(mar_seen), 64'd0);
    chk("deny fault_valid", 64'(fault_valid_o), 64'd1);
    chk("deny fault_addr", fault_addr_o, 64'h1000);
    chk("deny fault_cnt", 64'(fault_cnt_o), 64'd1);
    @(posedge clk); #1;

    // ordering: denial waits behind an outstanding allowed read
    r_hold = 1;
    issue(64'h8000_0100, 8'h01, 8'd0);
    wait_state(1);
    issue(64'h3000, 8'h02, 8'd0);
    beats = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_r_valid_o) beats++;
    end
    chk("order no early SLVERR", 64'(beats), 64'd0);
    r_hold = 0;
    wait_beat(resp, rid);
    chk("order first resp", 64'(resp), 64'd0);
    chk("order first id", 64'(rid), 64'h01);
    wait_beat(resp, rid);
    chk("order second resp", 64'(resp), 64'd2);
    chk("order second id", 64'(rid), 64'h02);
    wait_state(0);

    // outstanding limit
    r_hold = 1;
    issue(64'h8000_0000, 8'h10, 8'd1);
    wait_state(1);
    issue(64'h8000_0040, 8'h11, 8'd1);
    wait_state(2);
    issue(64'h8000_0080, 8'h12, 8'd1);
    repeat (5) @(negedge clk);
    chk("limit m_ar_valid held low", 64'(m_ar_valid_o), 64'd0);
    chk("limit s_ar_ready low", 64'(s_ar_ready_o), 64'd0);
    r_hold = 0;
    wait_state(0);

    // fault log
    pmp_mode = 2'd2;
    pulse_clear();
    issue(64'h100, 8'h31, 8'd0); wait_state(0);
    issue(64'h200, 8'h32, 8'd0); wait_state(0);
    issue(64'h300, 8'h33, 8'd0); wait_state(0);
    @(negedge clk);
    chk("log fault_addr", fault_addr_o, 64'h100);
    chk("log fault_cnt", 64'(fault_cnt_o), 64'd3);
    @(posedge clk); #1;
    pulse_clear();
    @(negedge clk);
    chk("clear fault_valid", 64'(fault_valid_o), 64'd0);
    chk("clear fault_cnt", 64'(fault_cnt_o), 64'd0);
    @(posedge clk); #1;
    issue(64'h500, 8'h35, 8'd0); wait_state(0);
    issue(64'h600, 8'h36, 8'd0);
    pulse_clear();  // lands on the CHECK->ERR edge of the 0x600 denial
    wait_state(0);
    @(negedge clk);
    chk("clear+deny fault_cnt", 64'(fault_cnt_o), 64'd1);
    chk("clear+deny fault_valid", 64'(fault_valid_o), 64'd1);
    chk("clear+deny fault_addr", fault_addr_o, 64'h600);
    @(posedge clk); #1;

    // randomized traffic
    pmp_mode = 2'd0;
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      ra = {$urandom, $urandom};
      issue(ra, 8'($urandom), 8'($urandom_range(0, 3)));
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      if ($urandom_range(0, 9) == 0) pulse_clear();
    end
    rnd = 0;
    wait_state(0);

    // reset during an SLVERR burst
    pmp_mode = 2'd2;
    issue(64'h700, 8'h07, 8'd7);
    beats = 0;
    for (int n = 0; n < 50 && beats < 2; n++) begin
      @(negedge clk);
      if (s_r_valid_o && s_r_ready_i && (s_r_resp_o == 2'b10)) beats++;
    end
    chk("rst-burst beats before reset", 64'(beats), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst s_r_valid", 64'(s_r_valid_o), 64'd0);
    chk("async rst s_ar_ready", 64'(s_ar_ready_o), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst s_ar_ready", 64'(s_ar_ready_o), 64'd1);
    chk("post-rst fault_cnt", 64'(fault_cnt_o), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
